// File: rtl/grid_world_env_if.sv
// Action/response bundle between the Q-learning agent (master) and the grid world environment (slave).
// Handshake: an action transfers on a rising edge where action_valid && action_ready; the agent holds action stable while valid is high, and out_valid is a one-cycle result pulse with no backpressure.
interface grid_world_env_if;
  logic [3:0]  action;
  logic        action_valid;
  logic        action_ready;
  logic [5:0]  next_state;
  logic [15:0] next_reward;
  logic        out_valid;
  logic        episode_done;

  modport master (
    output action,
    output action_valid,
    input  action_ready,
    input  next_state,
    input  next_reward,
    input  out_valid,
    input  episode_done
  );

  modport slave (
    input  action,
    input  action_valid,
    output action_ready,
    output next_state,
    output next_reward,
    output out_valid,
    output episode_done
  );
endinterface

// File: rtl/grid_world_env.sv
// 8x8 grid world environment: takes one-hot moves, returns the new cell and a Q8.8 reward,
// and handles walls, pit, goal, a per-episode step limit and automatic episode restart.
module grid_world_env #(
  parameter logic [5:0]  START_STATE = 6'd0,
  parameter logic [5:0]  GOAL_STATE  = 6'd63,
  parameter logic [5:0]  PIT_STATE   = 6'd27,
  parameter logic [7:0]  MAX_STEPS   = 8'd64,
  parameter logic [15:0] R_GOAL      = 16'h0100,
  parameter logic [15:0] R_PIT       = 16'hFF00,
  parameter logic [15:0] R_WALL      = 16'hFFC0,
  parameter logic [15:0] R_STEP      = 16'hFFF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  grid_world_env_if.slave   bus,
  output logic [7:0]        step_count,
  output logic [15:0]       episode_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESTART = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        ready_w;

  logic [5:0]  pos;
  logic [3:0]  act_q;

  logic [2:0]  row;
  logic [2:0]  col;
  logic [2:0]  new_row;
  logic [2:0]  new_col;
  logic        bump;
  logic [5:0]  new_pos;
  logic [15:0] reward;
  logic [7:0]  steps_inc;
  logic        terminal;

  assign bus.action_ready = ready_w;
  assign state_dbg        = state;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready_w  = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        ready_w = en;
        accept  = en && bus.action_valid;
        if (accept) begin
          state_nx = EVAL;
        end
      end
      EVAL: begin
        state_nx = terminal ? RESTART : IDLE;
      end
      RESTART: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Move evaluation on the latched action
  // ---------------------------------------------------------------------------
  always_comb begin
    row     = pos[5:3];
    col     = pos[2:0];
    new_row = row;
    new_col = col;
    bump    = 1'b0;
    // Anything that is not exactly one bit falls into default and is a no-op.
    case (act_q)
      4'b0001: begin
        if (row == 3'd0) bump = 1'b1;
        else             new_row = row - 3'd1;
      end
      4'b0010: begin
        if (row == 3'd7) bump = 1'b1;
        else             new_row = row + 3'd1;
      end
      4'b0100: begin
        if (col == 3'd0) bump = 1'b1;
        else             new_col = col - 3'd1;
      end
      4'b1000: begin
        if (col == 3'd7) bump = 1'b1;
        else             new_col = col + 3'd1;
      end
      default: begin
        bump = 1'b0;
      end
    endcase
  end

  assign new_pos = {new_row, new_col};

  always_comb begin
    reward = R_STEP;
    if (new_pos == GOAL_STATE)     reward = R_GOAL;
    else if (new_pos == PIT_STATE) reward = R_PIT;
    else if (bump)                 reward = R_WALL;
  end

  // Saturate so the counter can never pass the limit, even if MAX_STEPS is reached without restart.
  assign steps_inc = (step_count >= MAX_STEPS) ? MAX_STEPS : step_count + 8'd1;
  assign terminal  = (new_pos == GOAL_STATE) || (new_pos == PIT_STATE) || (steps_inc == MAX_STEPS);

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pos              <= START_STATE;
      act_q            <= 4'd0;
      bus.next_state   <= START_STATE;
      bus.next_reward  <= 16'd0;
      bus.out_valid    <= 1'b0;
      bus.episode_done <= 1'b0;
      step_count       <= 8'd0;
      episode_count    <= 16'd0;
    end else begin
      bus.out_valid    <= 1'b0;
      bus.episode_done <= 1'b0;
      if (accept) begin
        act_q <= bus.action;
      end
      case (state)
        EVAL: begin
          pos              <= new_pos;
          bus.next_state   <= new_pos;
          bus.next_reward  <= reward;
          bus.out_valid    <= 1'b1;
          bus.episode_done <= terminal;
          step_count       <= steps_inc;
          if (terminal) begin
            episode_count <= episode_count + 16'd1;
          end
        end
        RESTART: begin
          // next_state deliberately keeps the terminal cell for the agent.
          pos        <= START_STATE;
          step_count <= 8'd0;
        end
        default: begin
          pos <= pos;
        end
      endcase
    end
  end

endmodule

// File: doc/grid_world_env.md
Name: grid_world_env

Overview:
- Upstream/closed-loop environment stage for the Q-learning agent: an 8x8 grid world.
- Accepts one one-hot action per handshake and returns the resulting state and reward.
- Its next_state/next_reward outputs drive the agent's next_state/next_reward inputs.
- Handles wall bumps, a pit, a goal, a per-episode step limit and automatic episode restart.

Parameters:
- START_STATE, 6'd0, cell index where each episode begins.
- GOAL_STATE, 6'd63, terminal cell with positive reward.
- PIT_STATE, 6'd27, terminal cell with negative reward.
- MAX_STEPS, 8'd64, accepted actions per episode before timeout (1..255).
- R_GOAL, 16'h0100, goal reward, Q8.8 (+1.0).
- R_PIT, 16'hFF00, pit reward, Q8.8 (-1.0).
- R_WALL, 16'hFFC0, off-grid bump reward (-0.25).
- R_STEP, 16'hFFF0, ordinary move or no-op reward (-0.0625).

Ports:
- clk, in, 1: system clock; all logic on rising edge.
- rst, in, 1: synchronous active-high reset.
- en, in, 1: global enable; gates acceptance of new actions.
- action, in, 4: one-hot; [0]=up, [1]=down, [2]=left, [3]=right.
- action_valid, in, 1: action presented.
- action_ready, out, 1: environment can accept an action this cycle.
- next_state, out, 6: resulting cell, row*8+col (row=[5:3], col=[2:0]).
- next_reward, out, 16: Q8.8 two's-complement reward for the last step.
- out_valid, out, 1: one-cycle pulse; next_state/next_reward updated.
- episode_done, out, 1: one-cycle pulse coincident with out_valid on the terminal step.
- step_count, out, 8: accepted actions in the current episode.
- episode_count, out, 16: completed episodes; wraps 16'hFFFF->0.

Behaviour:
- Reset (rst=1 at edge, any state) sets:
  - FSM=IDLE; pos=START_STATE; next_state=START_STATE.
  - next_reward=0; out_valid=0; episode_done=0.
  - step_count=0; episode_count=0.
  - An in-flight step is discarded.
- FSM states and transitions:
  - IDLE: action_ready=en. Accept when action_valid & action_ready; go to EVAL.
  - EVAL (1 cycle): action_ready=0. Compute the move, register outputs, pulse out_valid. Go to RESTART if terminal, else IDLE.
  - RESTART (1 cycle): action_ready=0. pos=START_STATE; step_count=0; go to IDLE. next_state keeps showing the terminal cell.
- Timing:
  - Latency: out_valid asserts on the edge after the accept edge.
  - Max throughput: one action per 2 cycles, 3 cycles on terminal steps.
- Move rules:
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - Moving off the grid leaves pos unchanged with reward R_WALL. Position never wraps.
  - A non-one-hot action (0 or multiple bits) is a no-op: pos unchanged, reward R_STEP.
- Reward priority on the new cell: GOAL_STATE -> R_GOAL; PIT_STATE -> R_PIT; bump -> R_WALL; otherwise R_STEP.
- step_count increments at EVAL; it saturates at MAX_STEPS and is never exceeded.
- Terminal condition: new cell is GOAL or PIT, or step_count reaches MAX_STEPS after increment.
- On a terminal step:
  - episode_done pulses with out_valid.
  - episode_count increments exactly once, even if goal/pit and timeout coincide.
  - The reward follows the cell priority, not the timeout.
- A bump into the goal cannot happen, since pos is unchanged on a bump. If START_STATE equals GOAL or PIT, the episode ends only after a move/no-op evaluates onto it.
- en low during EVAL/RESTART does not stall them; en only blocks the next accept.
- Outputs hold their values between out_valid pulses.

Test Plan:
- Reset then idle: next_state=0, next_reward=0, action_ready=1, counters 0. With en=0, action_ready=0 and a valid action is ignored.
- From state 0, action=4'b0010 (down) -> out_valid 1 cycle later, next_state=8, next_reward=16'hFFF0, step_count=1.
- From state 0, action=4'b0001 (up) -> next_state=0, next_reward=16'hFFC0. action=4'b0011 -> next_state=0, next_reward=16'hFFF0.
- Drive 7x right then 7x down -> last response: next_state=63, next_reward=16'h0100, episode_done=1, episode_count=1. Next accept comes from state 0 with step_count reset.
- MAX_STEPS=4, bounce up/down in column 0 -> 4th response has episode_done=1, reward 16'hFFF0 or 16'hFFC0, and episode_count increments once.
- Navigate into cell 27 on step MAX_STEPS -> reward 16'hFF00, one done pulse. Asserting rst during EVAL yields no out_valid, and the state returns to 0.
